// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) single-port memory arbiter; optional round-robin via MEM_ARBITER_RR_EN
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [2:0]        mem_funct3,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic data_wins;
    logic own_if;
    logic own_d;

`ifdef MEM_ARBITER_RR_EN
    // Set when data should win the next contention, i.e. fetch was granted most recently.
    logic pref_data;

    always_comb begin
        data_wins = d_req && (!if_req || pref_data);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pref_data <= 1'b1;
        end else if (d_gnt) begin
            pref_data <= 1'b0;
        end else if (if_gnt) begin
            pref_data <= 1'b1;
        end
    end
`else
    always_comb begin
        data_wins = d_req;
    end
`endif

    always_comb begin
        d_gnt  = 1'b0;
        if_gnt = 1'b0;
        if (!reset) begin
            d_gnt  = data_wins;
            if_gnt = if_req && !data_wins;
        end
    end

    always_comb begin
        mem_addr   = if_addr;
        mem_funct3 = 3'b010;
        mem_wdata  = d_wdata;
        mem_wren   = 1'b0;
        if (d_gnt) begin
            mem_addr   = d_addr;
            mem_funct3 = d_funct3;
            mem_wren   = d_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            own_if <= 1'b0;
            own_d  <= 1'b0;
        end else begin
            own_if <= if_gnt;
            own_d  <= d_gnt;
        end
    end

    // Gating with reset drops the response of a grant made just before reset.
    assign if_rvalid = own_if && !reset;
    assign d_rvalid  = own_d && !reset;
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a grant/response model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [2:0]  d_funct3 = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        mem_wren;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata = '0;

    int n_checks = 0;
    int n_fail = 0;

    // Model: owner codes 0 = none, 1 = fetch, 2 = data.
    int prev_owner = 0;
    bit last_data = 1'b0;
    int exp_win;
    int exp_rv;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_funct3(mem_funct3),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic int winner(input bit r, input bit ir, input bit dr);
        if (r) return 0;
        if (ir && dr) begin
`ifdef MEM_ARBITER_RR_EN
            return last_data ? 1 : 2;
`else
            return 2;
`endif
        end
        if (dr) return 2;
        if (ir) return 1;
        return 0;
    endfunction

    // Applies one cycle of inputs, computes this cycle's expectations, advances the model.
    task automatic drive(input bit r, input bit ir, input logic [31:0] ia, input bit dr,
                         input bit dwe, input logic [2:0] f3, input logic [31:0] da,
                         input logic [31:0] dw);
        @(negedge clk);
        reset = r; if_req = ir; if_addr = ia; d_req = dr; d_we = dwe;
        d_funct3 = f3; d_addr = da; d_wdata = dw; mem_rdata = $urandom;
        exp_win = winner(r, ir, dr);
        exp_rv = r ? 0 : prev_owner;
        if (r) begin
            prev_owner = 0;
            last_data = 1'b0;
        end else begin
            prev_owner = exp_win;
            if (exp_win != 0) last_data = (exp_win == 2);
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 32'h10, 1, 1, 3'b010, 32'h20, 32'h5);
        drive(1, 1, 32'h10, 1, 1, 3'b010, 32'h20, 32'h5);
        n_checks++;
        if ({if_gnt, d_gnt, mem_wren, if_rvalid, d_rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000", {if_gnt, d_gnt, mem_wren, if_rvalid, d_rvalid});
        end
    endtask

    task automatic test_fetch();
        drive(0, 1, 32'h1000, 0, 0, 3'b000, 32'h0, 32'h0);
        n_checks++;
        if ({if_gnt, d_gnt} !== 2'b10 || mem_addr !== 32'h1000 || mem_funct3 !== 3'b010) begin
            n_fail++;
            $display("FAIL fetch_grant: gnt=%b addr=%h f3=%b want 10 00001000 010", {if_gnt, d_gnt}, mem_addr, mem_funct3);
        end
        drive(0, 0, 32'h0, 0, 0, 3'b000, 32'h0, 32'h0);
        n_checks++;
        if ({if_rvalid, d_rvalid} !== 2'b10 || rdata !== mem_rdata) begin
            n_fail++;
            $display("FAIL fetch_rvalid: rv=%b rdata=%h want 10 %h", {if_rvalid, d_rvalid}, rdata, mem_rdata);
        end
    endtask

    task automatic test_store();
        drive(0, 0, 32'h0, 1, 1, 3'b010, 32'h2004, 32'hDEADBEEF);
        n_checks++;
        if (d_gnt !== 1'b1 || mem_wren !== 1'b1 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h2004) begin
            n_fail++;
            $display("FAIL store_grant: gnt=%b wren=%b wdata=%h addr=%h want 1 1 deadbeef 00002004", d_gnt, mem_wren, mem_wdata, mem_addr);
        end
        drive(0, 0, 32'h0, 0, 0, 3'b000, 32'h0, 32'h0);
        n_checks++;
        if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0 || mem_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL store_done: d_rv=%b if_rv=%b wren=%b want 1 0 0", d_rvalid, if_rvalid, mem_wren);
        end
    endtask

    task automatic test_contention();
        logic [3:0] want_d;
`ifdef MEM_ARBITER_RR_EN
        want_d = 4'b0101;
`else
        want_d = 4'b1111;
`endif
        drive(1, 0, 32'h0, 0, 0, 3'b000, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'h3000, 1, 0, 3'b100, 32'h4000, 32'h0);
            n_checks++;
            if (d_gnt !== want_d[i] || if_gnt !== !want_d[i]) begin
                n_fail++;
                $display("FAIL contention[%0d]: d_gnt=%b if_gnt=%b want %b %b", i, d_gnt, if_gnt, want_d[i], !want_d[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 1, 32'h1000, 0, 0, 3'b000, 32'h0, 32'h0);
        drive(0, 0, 32'h0, 1, 0, 3'b010, 32'h2000, 32'h0);
        n_checks++;
        if ({d_gnt, if_rvalid, d_rvalid} !== 3'b110 || mem_addr !== 32'h2000) begin
            n_fail++;
            $display("FAIL b2b_cycle2: gnt/rv=%b addr=%h want 110 00002000", {d_gnt, if_rvalid, d_rvalid}, mem_addr);
        end
        drive(0, 0, 32'h0, 0, 0, 3'b000, 32'h0, 32'h0);
        n_checks++;
        if ({if_rvalid, d_rvalid} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_cycle3: rv=%b want 01", {if_rvalid, d_rvalid});
        end
    endtask

    task automatic test_reset_suppress();
        drive(0, 1, 32'h1000, 0, 0, 3'b000, 32'h0, 32'h0);
        drive(1, 0, 32'h0, 1, 1, 3'b010, 32'h0, 32'h1);
        n_checks++;
        if (if_rvalid !== 1'b0 || mem_wren !== 1'b0 || d_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_suppress: if_rv=%b wren=%b d_gnt=%b want 0 0 0", if_rvalid, mem_wren, d_gnt);
        end
        drive(0, 1, 32'h1000, 1, 0, 3'b010, 32'h2000, 32'h0);
        n_checks++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid} !== 4'b0100) begin
            n_fail++;
            $display("FAIL post_reset_contention: got %b want 0100", {if_gnt, d_gnt, if_rvalid, d_rvalid});
        end
    endtask

    task automatic test_random();
        logic [4:0] want_ctl;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                  $urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom);
            want_ctl = {exp_win == 1, exp_win == 2, exp_rv == 1, exp_rv == 2, exp_win == 2 && d_we};
            n_checks++;
            if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wren} !== want_ctl) begin
                n_fail++;
                $display("FAIL rand_ctl[%0d]: got %b want %b", i, {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wren}, want_ctl);
            end
            n_checks++;
            if (mem_addr !== (exp_win == 2 ? d_addr : if_addr) ||
                mem_funct3 !== (exp_win == 2 ? d_funct3 : 3'b010) ||
                mem_wdata !== d_wdata || rdata !== mem_rdata) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: addr=%h f3=%b wdata=%h rdata=%h win=%0d", i, mem_addr, mem_funct3, mem_wdata, rdata, exp_win);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_back_to_back();
        test_reset_suppress();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of both requesters and the memory port.
REQ-002 SHALL have parameter DATA_W, default 32, data width of the memory port.
REQ-003 SHALL have ports, in this order:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch requester wants a read.
- if_addr  input  ADDR_W  fetch address.
- if_gnt  output  1  fetch request accepted this cycle.
- if_rvalid  output  1  fetch read data valid this cycle.
- d_req  input  1  data requester wants an access.
- d_we  input  1  data access is a write.
- d_funct3  input  3  access size/sign, forwarded to memory.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_gnt  output  1  data request accepted this cycle.
- d_rvalid  output  1  data access complete (load data valid, or store done).
- rdata  output  DATA_W  shared read data, equal to mem_rdata.
- mem_addr  output  ADDR_W  memory address.
- mem_wren  output  1  memory write enable.
- mem_funct3  output  3  memory access size.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid one cycle after address.

Function
REQ-004 SHALL grant at most one requester per cycle; grant is combinational from req in the same cycle.
REQ-005 SHALL drive mem_addr/mem_funct3/mem_wdata from the granted requester; with no grant: mem_addr=if_addr, mem_funct3=3'b010, mem_wdata=d_wdata.
REQ-006 SHALL assert mem_wren only in a cycle where d_gnt=1 and d_we=1.
REQ-007 SHALL register the grant owner; exactly one cycle after a grant, SHALL assert that owner's rvalid for one cycle; other rvalid stays 0.
REQ-008 SHALL pulse d_rvalid for writes as well as reads (store completion).
REQ-009 SHALL allow back-to-back grants every cycle (rvalid of grant N coincides with grant N+1).
REQ-010 Requesters hold req/addr/data stable until gnt; arbiter SHALL NOT require req to drop after gnt.
REQ-011 Contention (both req): winner per REQ-016; loser's gnt=0, retried next cycle.
REQ-012 Single requester: granted immediately regardless of priority state.
REQ-013 rdata SHALL equal mem_rdata combinationally at all times.

Reset
REQ-014 While reset=1: if_gnt=0, d_gnt=0, mem_wren=0, both rvalid=0 in the following cycle; owner register cleared; round-robin pointer = data-preferred.
REQ-015 Reset asserted in the cycle after a grant SHALL suppress that grant's rvalid; no request is remembered across reset.

Configuration
REQ-016 Macro MEM_ARBITER_RR_EN:
- defined: round-robin; on contention grant the requester not granted most recently; pointer updates only on grants.
- undefined: fixed priority; data always wins contention, fetch granted only when d_req=0.

Verification
REQ-017 if_req=1, if_addr=0x1000, d_req=0 -> if_gnt=1, mem_addr=0x1000 same cycle; next cycle if_rvalid=1, rdata=mem_rdata.
REQ-018 d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF -> d_gnt=1, mem_wren=1, mem_wdata=0xDEADBEEF; next cycle d_rvalid=1, mem_wren=0.
REQ-019 Both req held 4 cycles, RR_EN undefined -> d_gnt=1 all 4 cycles, if_gnt=0; RR_EN defined -> grants D,F,D,F.
REQ-020 Fetch 0x1000 then load 0x2000 on consecutive cycles -> if_rvalid cycle 2, d_rvalid cycle 3, never both.
REQ-021 Grant fetch, assert reset next cycle -> if_rvalid=0, mem_wren=0; after release, first contention (RR_EN defined) grants data.
